io_input_debouncer: RTL and testbench

- Input-side companion to the IO-board LED driver: samples the Alchitry IO board's 5 pushbuttons and 24 DIP switches and synchronises them into clk.
- Debounces every input and presents clean levels, one-cycle press/release strobes per button, and a DIP-change strobe.
- Sits between the board input pins and user logic in top-level designs.

---
 rtl/io_board_pkg.sv | 16 +
 rtl/debounce_bit.sv | 67 ++++++
 rtl/io_input_debouncer.sv | 77 +++++++
 tb/tb_io_input_debouncer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/io_board_pkg.sv
// Shared constants and types for the IO-board driver/debouncer pair.
package io_board_pkg;

  localparam int N_BTN_DEFAULT        = 5;
  localparam int N_DIP_DEFAULT        = 24;
  localparam int N_LED                = 24;
  localparam int TICK_DIV_DEFAULT     = 100000;
  localparam int STABLE_TICKS_DEFAULT = 10;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } db_out_t;

endpackage

// File: rtl/debounce_bit.sv
// One debounced input: two-flop synchroniser, tick-gated stability counter,
// level register and registered rise/fall strobes.
module debounce_bit
  import io_board_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter bit INVERT       = 1'b0
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    raw_i,
  input  logic    tick_i,
  output db_out_t db_o
);

  localparam int              CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any sample matching the current level restarts the stability count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i ^ INVERT;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_o.level = level_q;
  assign db_o.rise  = rise_q;
  assign db_o.fall  = fall_q;

endmodule

// File: rtl/io_input_debouncer.sv
// Debouncer for the IO board's pushbuttons and DIP switches: one shared
// sample tick feeding a debounce_bit per input pin.
module io_input_debouncer
  import io_board_pkg::*;
#(
  parameter int TICK_DIV       = TICK_DIV_DEFAULT,
  parameter int STABLE_TICKS   = STABLE_TICKS_DEFAULT,
  parameter int N_BTN          = N_BTN_DEFAULT,
  parameter int N_DIP          = N_DIP_DEFAULT,
  parameter int BTN_ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_DIP-1:0] dip_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_DIP-1:0] dip_level,
  output logic             dip_changed
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tick_q, tick_d;
  logic             tick;
  db_out_t          btn_db [N_BTN];
  db_out_t          dip_db [N_DIP];
  logic [N_DIP-1:0] dip_upd;

  assign tick   = (tick_q == TICK_LAST);
  assign tick_d = tick ? '0 : tick_q + TW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .INVERT      (BTN_ACTIVE_LOW != 0)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw_i (btn_raw[gi]),
      .tick_i(tick),
      .db_o  (btn_db[gi])
    );
    assign btn_level[gi]   = btn_db[gi].level;
    assign btn_press[gi]   = btn_db[gi].rise;
    assign btn_release[gi] = btn_db[gi].fall;
  end

  for (genvar gi = 0; gi < N_DIP; gi++) begin : g_dip
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .INVERT      (1'b0)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw_i (dip_raw[gi]),
      .tick_i(tick),
      .db_o  (dip_db[gi])
    );
    assign dip_level[gi] = dip_db[gi].level;
    assign dip_upd[gi]   = dip_db[gi].rise | dip_db[gi].fall;
  end

  // The per-bit strobes are already registered, so the OR lines up with the level edge.
  assign dip_changed = |dip_upd;

endmodule

// File: tb/tb_io_input_debouncer.sv
// Directed bench for io_input_debouncer with TICK_DIV=4, STABLE_TICKS=3.
module tb_io_input_debouncer;

  localparam int TD = 4;
  localparam int ST = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btn_raw, btn_raw_al;
  logic [23:0] dip_raw, dip_raw_al;
  logic [4:0]  btn_level, btn_press, btn_release;
  logic [4:0]  btn_level_al, btn_press_al, btn_release_al;
  logic [23:0] dip_level, dip_level_al;
  logic        dip_changed, dip_changed_al;

  io_input_debouncer #(
    .TICK_DIV(TD), .STABLE_TICKS(ST), .N_BTN(5), .N_DIP(24), .BTN_ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .dip_raw(dip_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .dip_level(dip_level), .dip_changed(dip_changed)
  );

  io_input_debouncer #(
    .TICK_DIV(TD), .STABLE_TICKS(ST), .N_BTN(5), .N_DIP(24), .BTN_ACTIVE_LOW(1)
  ) u_dut_al (
    .clk(clk), .reset(reset), .btn_raw(btn_raw_al), .dip_raw(dip_raw_al),
    .btn_level(btn_level_al), .btn_press(btn_press_al), .btn_release(btn_release_al),
    .dip_level(dip_level_al), .dip_changed(dip_changed_al)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int press_cnt [5];
  int rel_cnt   [5];
  int dipchg_cnt;
  int press_al_cnt [5];
  int strobe_al_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    dipchg_cnt = 0;
  endtask

  task automatic clear_al_counts();
    for (int i = 0; i < 5; i++) press_al_cnt[i] = 0;
    strobe_al_cnt = 0;
  endtask

  // Advance one clock and tally strobes seen at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (btn_press[i])      press_cnt[i]++;
      if (btn_release[i])    rel_cnt[i]++;
      if (btn_press_al[i])   press_al_cnt[i]++;
      if (btn_press_al[i] || btn_release_al[i]) strobe_al_cnt++;
    end
    if (dip_changed) dipchg_cnt++;
  endtask

  initial begin
    int lat;
    int found;
    int lvl_seen;

    btn_raw    = 5'h1F;
    dip_raw    = 24'hFFFFFF;
    btn_raw_al = 5'h1F;
    dip_raw_al = 24'h0;
    reset      = 1'b1;
    clear_counts();
    clear_al_counts();

    // Reset held with every raw input high
    repeat (5) begin
      step();
      check("rst_btn_outs", {11'd0, btn_level, btn_press, btn_release, dip_changed}, 32'd0);
      check("rst_dip_level", {8'd0, dip_level}, 32'd0);
    end
    reset = 1'b0;
    clear_counts();
    clear_al_counts();
    repeat (15) step();
    check("post_rst_btn_level", {27'd0, btn_level}, 32'h1F);
    check("post_rst_dip_level", {8'd0, dip_level}, 32'hFFFFFF);
    for (int i = 0; i < 5; i++)
      check($sformatf("post_rst_press_cnt%0d", i), press_cnt[i], 1);
    check("post_rst_dipchg_cnt", dipchg_cnt, 1);
    check("al_idle_level", {27'd0, btn_level_al}, 32'd0);
    check("al_idle_strobes", strobe_al_cnt, 0);

    // Drop everything back to 0
    btn_raw = 5'h00;
    dip_raw = 24'h0;
    clear_counts();
    repeat (20) step();
    check("idle_btn_level", {27'd0, btn_level}, 32'd0);
    check("idle_dip_level", {8'd0, dip_level}, 32'd0);
    check("idle_release_cnt0", rel_cnt[0], 1);
    check("idle_dipchg_cnt", dipchg_cnt, 1);

    // Clean press on button 0
    clear_counts();
    btn_raw[0] = 1'b1;
    lat = 0; found = 0;
    while (found == 0 && lat < 30) begin
      step();
      lat++;
      if (btn_press[0]) found = 1;
    end
    check("press_seen", found, 1);
    check("press_latency_ok", (lat >= 11 && lat <= 15), 1);
    check("press_level", btn_level[0], 1);
    step();
    check("press_one_cycle", btn_press[0], 0);
    repeat (10) step();
    check("press_cnt0", press_cnt[0], 1);
    check("press_no_release", rel_cnt[0], 0);

    // Clean release on button 0
    clear_counts();
    btn_raw[0] = 1'b0;
    lat = 0; found = 0;
    while (found == 0 && lat < 30) begin
      step();
      lat++;
      if (btn_release[0]) found = 1;
    end
    check("release_seen", found, 1);
    check("release_latency_ok", (lat >= 11 && lat <= 15), 1);
    check("release_level", btn_level[0], 0);
    step();
    check("release_one_cycle", btn_release[0], 0);
    repeat (10) step();
    check("release_cnt0", rel_cnt[0], 1);

    // Bounce on button 2: 5-cycle phases never span three ticks
    clear_counts();
    for (int t = 0; t < 12; t++) begin
      btn_raw[2] = ~btn_raw[2];
      repeat (5) step();
    end
    check("bounce_no_press", press_cnt[2], 0);
    check("bounce_no_release", rel_cnt[2], 0);
    check("bounce_level", btn_level[2], 0);
    btn_raw[2] = 1'b1;
    repeat (20) step();
    check("bounce_press_cnt", press_cnt[2], 1);
    check("bounce_level_settled", btn_level[2], 1);

    // All A5A5A5 DIP bits change together
    clear_counts();
    dip_raw = 24'hA5A5A5;
    repeat (20) step();
    check("simul_dip_level", {8'd0, dip_level}, 32'hA5A5A5);
    check("simul_dipchg_cnt", dipchg_cnt, 1);

    // Reset pulse in the middle of a count on button 1
    clear_counts();
    btn_raw[1] = 1'b1;
    repeat (8) step();
    check("rmc_not_yet", btn_level[1], 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rmc_cleared", {5'd0, btn_level, dip_level}, 32'd0);
    clear_counts();
    lvl_seen = 0;
    repeat (11) begin
      step();
      if (btn_level[1]) lvl_seen = 1;
    end
    check("rmc_hold_low", lvl_seen, 0);
    repeat (15) step();
    check("rmc_press_cnt", press_cnt[1], 1);
    check("rmc_level", btn_level[1], 1);

    // Active-low instance: idle high pins read as released
    check("al_still_idle", strobe_al_cnt, 0);
    clear_al_counts();
    btn_raw_al[4] = 1'b0;
    repeat (20) step();
    check("al_press_cnt4", press_al_cnt[4], 1);
    check("al_strobe_total", strobe_al_cnt, 1);
    check("al_level", {27'd0, btn_level_al}, 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
